// File: rtl/conv_pkg.sv
// Shared state encoding and geometry constants for the convolution sequencer.
// Optional zero-border streaming is enabled with CONV_SEQ_PAD_EN.
package conv_pkg;

    localparam int KW_DEF = 3;
    localparam int ADDR_W = 16;
    localparam int RC_W   = 8;
    localparam int WA_W   = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WLOAD  = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_FLUSH  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

endpackage

// File: rtl/conv_raster_cnt.sv
// Row/column raster counter: column runs fastest, both wrap to 0 after the
// last position. Holds while en_i is low. Feature macro: CONV_SEQ_PAD_EN.
module conv_raster_cnt
    import conv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [RC_W-1:0] max_i,
    output logic [RC_W-1:0] row_o,
    output logic [RC_W-1:0] col_o,
    output logic            last_o
);

    logic [RC_W-1:0] row_q, row_d;
    logic [RC_W-1:0] col_q, col_d;

    assign last_o = (row_q == max_i) && (col_q == max_i);
    assign row_o  = row_q;
    assign col_o  = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == max_i) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution pass sequencer: weight load, raster image stream, window tracking.
// Define CONV_SEQ_PAD_EN to stream a one-pixel zero border (adds pad_zero).
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int SIZE = 14,
    parameter int KW   = KW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              w_rd,
    output logic [WA_W-1:0]   w_addr,
    output logic              i_rd,
    output logic [ADDR_W-1:0] i_addr,
    output logic              lb_load,
`ifdef CONV_SEQ_PAD_EN
    output logic              pad_zero,
`endif
    output logic              out_valid,
    output logic [RC_W-1:0]   out_row,
    output logic [RC_W-1:0]   out_col
);

`ifdef CONV_SEQ_PAD_EN
    localparam int SPAN = SIZE + 2;
`else
    localparam int SPAN = SIZE;
`endif
    localparam logic [RC_W-1:0] LAST_RC = RC_W'(SPAN - 1);
    localparam logic [RC_W-1:0] WIN_OFS = RC_W'(KW - 1);
    localparam logic [WA_W-1:0] W_LAST  = WA_W'(KW * KW - 1);

    state_t          state_q, state_d;
    logic [WA_W-1:0] w_cnt_q, w_cnt_d;
    logic            lb_q, valid_q;
    logic [RC_W-1:0] orow_q, ocol_q;
    logic [RC_W-1:0] row, col;
    logic            last, step, win, border;

    assign step = (state_q == S_STREAM) && !stall;
    assign win  = (row >= WIN_OFS) && (col >= WIN_OFS);

    conv_raster_cnt u_raster (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .clr_i  (state_q == S_IDLE),
        .en_i   (step),
        .max_i  (LAST_RC),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

`ifdef CONV_SEQ_PAD_EN
    logic pad_q;

    // Border positions carry no memory read; image is offset by one pixel.
    assign border = (row == '0) || (col == '0) ||
                    (row == LAST_RC) || (col == LAST_RC);
    assign i_addr = border ? '0 :
                    {row - RC_W'(1), col - RC_W'(1)};
    assign pad_zero = pad_q;

    always_ff @(posedge clk) begin
        if (rst_n) pad_q <= 1'b0;
        else       pad_q <= step && border;
    end
`else
    assign border = 1'b0;
    assign i_addr = {row, col};
`endif

    always_comb begin
        state_d = state_q;
        w_cnt_d = w_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WLOAD;
                    w_cnt_d = '0;
                end
            end
            S_WLOAD: begin
                if (!stall) begin
                    if (w_cnt_q == W_LAST) begin
                        state_d = S_STREAM;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: if (!stall && last) state_d = S_FLUSH;
            S_FLUSH:  if (!stall) state_d = S_DONE;
            S_DONE:   if (!stall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read data arrives one cycle after the address, so strobes are delayed.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            w_cnt_q <= '0;
            lb_q    <= 1'b0;
            valid_q <= 1'b0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            state_q <= state_d;
            w_cnt_q <= w_cnt_d;
            lb_q    <= step;
            valid_q <= step && win;
            if (step && win) begin
                orow_q <= row - WIN_OFS;
                ocol_q <= col - WIN_OFS;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) && !stall;
    assign w_rd      = (state_q == S_WLOAD) && !stall;
    assign w_addr    = w_cnt_q;
    assign i_rd      = step && !border;
    assign lb_load   = lb_q;
    assign out_valid = valid_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl with a queue-based reference model.
// Covers both the default build and CONV_SEQ_PAD_EN.
module tb_conv_seq_ctrl;

    localparam int SIZE = 14;
    localparam int KW   = 3;
`ifdef CONV_SEQ_PAD_EN
    localparam int P = SIZE + 2;
`else
    localparam int P = SIZE;
`endif
    localparam int NW       = P - KW + 1;
    localparam int NPIX     = SIZE * SIZE;
    localparam int PASS_LEN = KW * KW + P * P + 2;
    localparam int MAXREL   = 4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        busy, done, w_rd, i_rd, lb_load, out_valid, pad_zero;
    logic [3:0]  w_addr;
    logic [15:0] i_addr;
    logic [7:0]  out_row, out_col;

    conv_seq_ctrl #(.SIZE(SIZE), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .w_rd      (w_rd),
        .w_addr    (w_addr),
        .i_rd      (i_rd),
        .i_addr    (i_addr),
        .lb_load   (lb_load),
`ifdef CONV_SEQ_PAD_EN
        .pad_zero  (pad_zero),
`endif
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col)
    );

`ifndef CONV_SEQ_PAD_EN
    assign pad_zero = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int t0 = 0;
    int wq[$], iq[$], vq[$];
    int exp_w[$], exp_i[$], exp_v[$];
    int n_done, done_rel, n_lb, n_pad, lb_err, win_err;
    int first_w_rel, first_i_rel;
    bit timed_out;
    bit stall_at [0:MAXREL-1];
    logic prev_i_rd = 1'b0;
    logic [15:0] prev_i_addr = '0;

    // Passive recorder: collects what the DUT emits each cycle.
    always @(negedge clk) begin
        if (w_rd) begin
            wq.push_back(int'(w_addr));
            if (first_w_rel < 0) first_w_rel = cyc - t0;
        end
        if (i_rd) begin
            iq.push_back(int'(i_addr));
            if (first_i_rel < 0) first_i_rel = cyc - t0;
        end
        if (out_valid) vq.push_back(int'({out_row, out_col}));
        if (done) begin
            n_done++;
            done_rel = cyc - t0;
        end
        if (lb_load) n_lb++;
        if (pad_zero) n_pad++;
`ifdef CONV_SEQ_PAD_EN
        if (pad_zero && (!lb_load || prev_i_rd)) lb_err++;
        if (lb_load && !pad_zero && !prev_i_rd) lb_err++;
        if (!lb_load && prev_i_rd) lb_err++;
`else
        if (lb_load !== prev_i_rd) lb_err++;
        if (out_valid &&
            prev_i_addr !== {out_row + 8'(KW - 1), out_col + 8'(KW - 1)})
            win_err++;
`endif
        prev_i_rd   = i_rd;
        prev_i_addr = i_addr;
    end

    function automatic int qdiff(input int a[$], input int b[$]);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int k = 0; k < a.size() && k < b.size(); k++)
            if (a[k] != b[k]) d++;
        return d;
    endfunction

    function automatic int exp_done_rel();
        int run;
        run = 0;
        for (int t = 1; t < MAXREL; t++) begin
            if (!stall_at[t]) run++;
            if (run == PASS_LEN) return t;
        end
        return -1;
    endfunction

    task automatic build_model();
        exp_w.delete(); exp_i.delete(); exp_v.delete();
        for (int k = 0; k < KW * KW; k++) exp_w.push_back(k);
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++) begin
`ifdef CONV_SEQ_PAD_EN
                if (r != 0 && c != 0 && r != P - 1 && c != P - 1)
                    exp_i.push_back(((r - 1) << 8) | (c - 1));
`else
                exp_i.push_back((r << 8) | c);
`endif
            end
        for (int r = 0; r < NW; r++)
            for (int c = 0; c < NW; c++)
                exp_v.push_back((r << 8) | c);
    endtask

    task automatic clear_mon();
        wq.delete(); iq.delete(); vq.delete();
        n_done = 0; done_rel = -1; n_lb = 0; n_pad = 0;
        lb_err = 0; win_err = 0;
        first_w_rel = -1; first_i_rel = -1;
        for (int k = 0; k < MAXREL; k++) stall_at[k] = 1'b0;
    endtask

    task automatic launch();
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives stall per cycle until done is seen; called at rel cycle 1.
    task automatic run_pass(input int pct, input int lo, input int hi,
                            input int mid_start);
        int rel;
        rel = 1;
        timed_out = 1'b0;
        while (n_done == 0 && !timed_out) begin
            stall = ($urandom_range(99) < pct) || (rel >= lo && rel <= hi);
            stall_at[rel] = stall;
            start = (rel == mid_start);
            @(posedge clk); #1;
            rel++;
            if (rel >= MAXREL - 1) timed_out = 1'b1;
        end
        stall = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, w_rd, i_rd, lb_load, out_valid, pad_zero, w_addr,
             i_addr, out_row, out_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b i_addr=%h, need all 0",
                     busy, i_addr);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b need 0", busy);
        end
    endtask

    task automatic test_basic();
        launch();
        run_pass(0, -1, -1, -1);
        n_checks++;
        if (timed_out) begin
            n_fail++; $display("FAIL basic_timeout: no done in budget");
        end
        n_checks++;
        if (qdiff(wq, exp_w) != 0) begin
            n_fail++; $display("FAIL basic_waddr: %0d reads, need %0d", wq.size(), exp_w.size());
        end
        n_checks++;
        if (first_w_rel != 1) begin
            n_fail++; $display("FAIL basic_wfirst: cycle %0d need 1", first_w_rel);
        end
        n_checks++;
        if (first_i_rel != KW * KW + 1) begin
            n_fail++; $display("FAIL basic_ifirst: cycle %0d need %0d", first_i_rel, KW * KW + 1);
        end
        n_checks++;
        if (qdiff(iq, exp_i) != 0) begin
            n_fail++; $display("FAIL basic_iaddr: %0d reads, need %0d", iq.size(), exp_i.size());
        end
        n_checks++;
        if (qdiff(vq, exp_v) != 0) begin
            n_fail++; $display("FAIL basic_windows: %0d windows, need %0d", vq.size(), exp_v.size());
        end
        n_checks++;
        if (vq.size() == 0 || vq[0] != 0) begin
            n_fail++; $display("FAIL basic_first_win: got %0d need 0", vq.size() ? vq[0] : -1);
        end
        n_checks++;
        if (vq.size() == 0 || vq[$] != (((NW - 1) << 8) | (NW - 1))) begin
            n_fail++; $display("FAIL basic_last_win: got %h need %h",
                               vq.size() ? vq[$] : -1, ((NW - 1) << 8) | (NW - 1));
        end
        n_checks++;
        if (n_done != 1 || done_rel != PASS_LEN) begin
            n_fail++; $display("FAIL basic_done: %0d pulses at %0d, need 1 at %0d",
                               n_done, done_rel, PASS_LEN);
        end
        n_checks++;
        if (n_lb != P * P || n_pad != P * P - NPIX) begin
            n_fail++; $display("FAIL basic_loads: lb=%0d pad=%0d need %0d/%0d",
                               n_lb, n_pad, P * P, P * P - NPIX);
        end
        n_checks++;
        if (lb_err != 0 || win_err != 0) begin
            n_fail++; $display("FAIL basic_align: lb_err=%0d win_err=%0d need 0/0",
                               lb_err, win_err);
        end
    endtask

    task automatic test_stall_mid();
        int lo;
        lo = KW * KW + 1 + 4 * P + 6;
        launch();
        run_pass(0, lo, lo + 4, -1);
        n_checks++;
        if (qdiff(iq, exp_i) != 0) begin
            n_fail++; $display("FAIL stall_iaddr: %0d reads, need %0d", iq.size(), exp_i.size());
        end
        n_checks++;
        if (qdiff(vq, exp_v) != 0) begin
            n_fail++; $display("FAIL stall_windows: %0d windows, need %0d", vq.size(), exp_v.size());
        end
        n_checks++;
        if (n_done != 1 || done_rel != PASS_LEN + 5) begin
            n_fail++; $display("FAIL stall_done: %0d pulses at %0d, need 1 at %0d",
                               n_done, done_rel, PASS_LEN + 5);
        end
        n_checks++;
        if (lb_err != 0 || win_err != 0 || n_lb != P * P) begin
            n_fail++; $display("FAIL stall_align: lb_err=%0d win_err=%0d lb=%0d need 0/0/%0d",
                               lb_err, win_err, n_lb, P * P);
        end
    endtask

    task automatic test_random_stall();
        for (int pass = 0; pass < 3; pass++) begin
            launch();
            run_pass(10 + 10 * pass, -1, -1, -1);
            n_checks++;
            if (qdiff(wq, exp_w) != 0 || qdiff(iq, exp_i) != 0) begin
                n_fail++; $display("FAIL rand_reads: pass %0d w=%0d i=%0d need %0d/%0d",
                                   pass, wq.size(), iq.size(), exp_w.size(), exp_i.size());
            end
            n_checks++;
            if (qdiff(vq, exp_v) != 0) begin
                n_fail++; $display("FAIL rand_windows: pass %0d got %0d need %0d",
                                   pass, vq.size(), exp_v.size());
            end
            n_checks++;
            if (n_done != 1 || done_rel != exp_done_rel()) begin
                n_fail++; $display("FAIL rand_done: pass %0d %0d pulses at %0d need 1 at %0d",
                                   pass, n_done, done_rel, exp_done_rel());
            end
            n_checks++;
            if (lb_err != 0 || win_err != 0 || n_pad != P * P - NPIX) begin
                n_fail++; $display("FAIL rand_align: lb_err=%0d win_err=%0d pad=%0d",
                                   lb_err, win_err, n_pad);
            end
        end
    endtask

    task automatic test_start_ignored();
        launch();
        run_pass(0, -1, -1, KW * KW + 40);
        n_checks++;
        if (n_done != 1 || done_rel != PASS_LEN) begin
            n_fail++; $display("FAIL restart_done: %0d pulses at %0d need 1 at %0d",
                               n_done, done_rel, PASS_LEN);
        end
        n_checks++;
        if (qdiff(iq, exp_i) != 0) begin
            n_fail++; $display("FAIL restart_iaddr: %0d reads need %0d", iq.size(), exp_i.size());
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_done != 1) begin
            n_fail++; $display("FAIL restart_idle: busy=%b done=%0d need 0/1", busy, n_done);
        end
    endtask

    task automatic test_reset_mid();
        launch();
        repeat (99) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, w_rd, i_rd, lb_load, out_valid, pad_zero, w_addr,
             i_addr, out_row, out_col} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b i_rd=%b lb=%b i_addr=%h need all 0",
                     busy, i_rd, lb_load, i_addr);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_nodone: done=%0d busy=%b need 0/0", n_done, busy);
        end
        launch();
        run_pass(0, -1, -1, -1);
        n_checks++;
        if (qdiff(wq, exp_w) != 0 || qdiff(iq, exp_i) != 0 || qdiff(vq, exp_v) != 0) begin
            n_fail++; $display("FAIL abort_rerun: w=%0d i=%0d v=%0d need %0d/%0d/%0d",
                               wq.size(), iq.size(), vq.size(),
                               exp_w.size(), exp_i.size(), exp_v.size());
        end
        n_checks++;
        if (n_done != 1 || done_rel != PASS_LEN || first_w_rel != 1) begin
            n_fail++; $display("FAIL abort_rerun_done: %0d at %0d wfirst %0d need 1 at %0d/1",
                               n_done, done_rel, first_w_rel, PASS_LEN);
        end
    endtask

    initial begin
        build_model();
        clear_mon();
        test_reset();
        test_basic();
        test_stall_mid();
        test_random_stall();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 14: image edge in pixels (rows = cols = SIZE), legal range 3..255.
REQ-002 SHALL have parameter KW, default 3: kernel edge; the weight count is KW*KW.
REQ-003 SHALL have port clk, in, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, in, 1: reset, synchronous and active-high (1 = reset).
REQ-005 SHALL have port start, in, 1: one-cycle request to run one convolution pass.
REQ-006 SHALL have port stall, in, 1: downstream hold; freezes the sequence while 1.
REQ-007 SHALL have port busy, out, 1: high in every state except IDLE.
REQ-008 SHALL have port done, out, 1: one-cycle pulse at the end of a pass.
REQ-009 SHALL have port w_rd, out, 1: weight memory read enable.
REQ-010 SHALL have port w_addr, out, 4: weight index, 0..KW*KW-1.
REQ-011 SHALL have port i_rd, out, 1: image memory read enable.
REQ-012 SHALL have port i_addr, out, 16: image address {row[7:0], col[7:0]}.
REQ-013 SHALL have port lb_load, out, 1: shift-enable to the line buffer; marks image data valid this cycle.
REQ-014 SHALL have port out_valid, out, 1: the line buffer holds a complete KW x KW window.
REQ-015 SHALL have port out_row and out_col, out, 8 each: top-left coordinate of the current window.

Function
REQ-016 SHALL implement FSM states IDLE, WLOAD, STREAM, FLUSH, DONE.
REQ-017 SHALL move IDLE->WLOAD on the cycle after start=1; start SHALL be ignored in all other states.
REQ-018 In WLOAD, SHALL assert w_rd with w_addr 0..KW*KW-1, one per cycle, then enter STREAM.
REQ-019 In STREAM, SHALL assert i_rd and issue i_addr in raster order, col fastest, (0,0) to (SIZE-1,SIZE-1), one per cycle.
REQ-020 SHALL treat memory read latency as 1 cycle: lb_load is i_rd delayed by one cycle.
REQ-021 SHALL assert out_valid in the cycle lb_load delivers pixel (r,c) with r>=KW-1 and c>=KW-1, with out_row=r-KW+1 and out_col=c-KW+1.
REQ-022 SHALL move STREAM->FLUSH after the last address, FLUSH->DONE after the final lb_load, and DONE->IDLE after one cycle with done=1.
REQ-023 While stall=1, SHALL hold all counters and state and drive i_rd=0 and w_rd=0; the pending lb_load/out_valid SHALL be delivered once and then held low until stall=0.
REQ-024 SHALL wrap col to 0 and increment row at col=SIZE-1, with no gaps between rows.
REQ-025 Per pass, SHALL produce exactly (SIZE-KW+1)^2 out_valid cycles and SIZE*SIZE i_rd cycles.

Reset
REQ-026 rst_n=1 at any clock edge SHALL force IDLE and clear all counters; every output SHALL be 0 on the following cycle.
REQ-027 Reset mid-pass SHALL abort without a done pulse; the next start SHALL begin a fresh pass from WLOAD.

Configuration
REQ-028 When CONV_SEQ_PAD_EN is defined, SHALL stream (SIZE+2)^2 positions covering a one-pixel zero border.
- i_rd=0 at border positions.
- out pad_zero (1 bit) asserted with lb_load at border positions.
- SIZE^2 windows produced.
REQ-029 When CONV_SEQ_PAD_EN is undefined, SHALL have no pad_zero port and SHALL behave as in REQ-019..REQ-025.

Structure
REQ-030 SHALL place the FSM state typedef and KW, address-width and row/col-width constants in shared package conv_pkg.
REQ-031 SHALL place the row/col raster counter (enable, hold, wrap, last flag) in one sub-module, conv_raster_cnt.

Verification
REQ-032 Scenario: SIZE=14, start pulse at cycle 0, no stall -> w_rd cycles 1..9, i_rd cycles 10..205 (196 reads), 144 out_valid cycles, done at cycle 207.
REQ-033 Scenario: first and last window -> first out_valid when pixel (2,2) loads, with out_row/out_col=0/0; last window has out_row/out_col=11/11.
REQ-034 Scenario: stall=1 for 5 cycles mid-row 4 -> no i_addr skipped or repeated, 144 windows total, done delayed by exactly 5 cycles.
REQ-035 Scenario: start asserted during STREAM -> ignored; exactly one done pulse.
REQ-036 Scenario: rst_n pulse at cycle 100 -> all outputs 0 at cycle 101, no done; a new start gives the full REQ-032 sequence.
REQ-037 Scenario: CONV_SEQ_PAD_EN defined, SIZE=14 -> 256 positions, 196 i_rd, 60 pad_zero, 196 out_valid.
